mnist_frame_loader: RTL and testbench
=====================================

# mnist_frame_loader

Stream-side front end for the MLP inference top. It accepts one MNIST frame as a byte-wide pixel stream with valid/ready, converts each pixel to Q16.16, and holds the 784-word frame stable on `pixel_out`. It then releases the inference core from reset and waits a fixed settle time. Finally it samples the predicted class and returns it on a byte-wide result handshake. It is the writer/driver for the inference top's `pixel_in`/`rstn`, and the reader of its `pred_out`.

## Interface
- `NPIX`, 784: pixels per frame.
- `SETTLE_CYCLES`, 900: cycles the core runs after reset release before `pred_in` is sampled (≥ layer-1 + layer-2 counter span + 2 pipeline).
- `IDX_W`, 10: pixel index width, ≥ clog2(NPIX).
- `CNT_W`, 12: settle counter width, ≥ clog2(SETTLE_CYCLES+1).
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `s_pix_data` in 8: unsigned pixel, 0..255.
- `s_pix_valid` in 1: pixel beat valid.
- `s_pix_ready` out 1: loader accepts a beat.
- `s_pix_last` in 1: marks final beat of frame.
- `pixel_out` out NPIX×32 signed: Q16.16 frame buffer, index 0 = first beat.
- `nn_rstn` out 1: active-low reset to inference core.
- `pred_in` in 4: argmax from inference core.
- `m_res_data` out 8: {err, 3'b000, pred[3:0]}.
- `m_res_valid` out 1: result valid.
- `m_res_ready` in 1: result consumed.
- `busy` out 1: high in every state except LOAD with idx==0.

## Operation
- FSM states: LOAD, DRAIN, SETTLE, RESULT. Reset state is LOAD with idx=0 and err=0.
- **LOAD:** `s_pix_ready`=1. On each handshake, `buf[idx] <= conv(s_pix_data)` and idx increments. Transitions:
  - Beat with `s_pix_last`=1 and idx<NPIX-1: short frame. err=1, remaining entries keep prior contents, go to RESULT with pred field 0.
  - Beat at idx==NPIX-1 with `s_pix_last`=1: go to SETTLE.
  - Beat at idx==NPIX-1 without last: err=1, go to DRAIN.
- **DRAIN:** `s_pix_ready`=1. Beats are discarded until a beat with `s_pix_last`=1, then go to SETTLE. An oversized frame still runs inference on its first NPIX pixels.
- **SETTLE:** `s_pix_ready`=0, `nn_rstn`=1, counter counts 0..SETTLE_CYCLES-1. On the final count, capture `pred_in` into the result register and go to RESULT.
- **RESULT:** `m_res_valid`=1, `m_res_data` stable. On `m_res_ready` the handshake completes, idx and err clear, and the FSM returns to LOAD.
- `nn_rstn`=0 in LOAD, DRAIN and RESULT, so the core restarts cleanly each frame.
- Conversion `conv(p)`, 32-bit signed, always non-negative: {16'h0, p, 8'h00} = p/256.
- `pixel_out` is registered directly from `buf`. It changes only on LOAD handshakes and is stable through DRAIN, SETTLE and RESULT.

## Timing
- Reset values:
  - `s_pix_ready`=1, `m_res_valid`=0, `m_res_data`=0, `nn_rstn`=0, `busy`=0.
  - All `pixel_out` words = 0.
- A pixel is visible on `pixel_out` one cycle after its handshake.
- `nn_rstn` rises on the first SETTLE cycle, registered with no glitch.
- `m_res_valid` rises exactly SETTLE_CYCLES cycles after `nn_rstn` rises. For a short frame it rises one cycle after the last handshake.
- `s_pix_ready` deasserts the cycle after the terminating beat.
- The FSM does not stall mid-frame: there is no throughput limit in LOAD, so one beat can be accepted per cycle.
- `m_res_valid` holds until accepted. `m_res_data` does not change while valid.
- Back-to-back frames: the first LOAD cycle after a RESULT handshake can accept a beat.
- `rstn` asserted in any state returns to the reset values immediately (asynchronous) and discards any partial frame or pending result.

## Configuration
- `MNIST_LOADER_NORMALIZE_EN`:
  - Defined: `conv(p)` = p×257 (i.e. {16'h0, p, p}), which gives p/255 to within 1 LSB, so 255 maps to 0x0000FFFF.
  - Undefined: `conv(p)` = p<<8, so 255 maps to 0x0000FF00.
  - Everything else is identical.

## Structure
- Shared package `mnist_pkg`: `q16_t` (signed 32-bit), `NPIX`, the `loader_state_e` enum, and function `pix_to_q16(byte)` containing the ifdef.
- Sub-module `mnist_settle_timer`: a load/start-to-done down-counter parameterised by SETTLE_CYCLES, reused by later pipeline wrappers.

## Test plan
- **Nominal frame:** 784 beats with value i%256, last on beat 783 → `pixel_out[5]`=0x00000500. `nn_rstn` rises, and 900 cycles later `m_res_data`={0,000,`pred_in`} with `pred_in` forced to 7, i.e. 0x07.
- **Short frame:** last on beat 99 → no `nn_rstn` rise, `m_res_data`=0x80 one cycle later. The next frame loads from index 0.
- **Long frame:** 790 beats, last on beat 789 → beats 784..789 not written, SETTLE runs, `m_res_data`=0x80|pred.
- **Result backpressure:** `m_res_ready` held low 50 cycles → valid and data stable, `s_pix_ready`=0 throughout, then return to LOAD the cycle after the handshake.
- **Reset mid-frame:** `rstn` pulsed at beat 400 → all outputs return to their reset values. A fresh 784-beat frame then completes normally.
- **Macro on vs. off:** pixel 255 → `pixel_out` word 0x0000FFFF when defined, 0x0000FF00 when undefined.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared types and pixel conversion for the MNIST loader and later pipeline wrappers.
// MNIST_LOADER_NORMALIZE_EN selects p*257 (p/255) instead of p<<8 (p/256).
package mnist_pkg;

  typedef logic signed [31:0] q16_t;

  localparam int NPIX = 784;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESULT = 2'd3
  } loader_state_e;

  function automatic q16_t pix_to_q16(input logic [7:0] p);
`ifdef MNIST_LOADER_NORMALIZE_EN
    return q16_t'({16'h0000, p, p});
`else
    return q16_t'({16'h0000, p, 8'h00});
`endif
  endfunction

endpackage

// File: rtl/mnist_settle_timer.sv
// Start-to-done down-counter: done_o pulses in the SETTLE_CYCLES-th cycle after start_i.
module mnist_settle_timer #(
  parameter int SETTLE_CYCLES = 900,
  parameter int CNT_W         = 12
) (
  input  logic clk,
  input  logic rstn,
  input  logic start_i,
  output logic done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      cnt_d = CNT_W'(SETTLE_CYCLES - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/mnist_frame_loader.sv
// Loads one MNIST frame into a Q16.16 buffer, runs the inference core for a fixed
// settle time, and returns the predicted class. Conversion honours MNIST_LOADER_NORMALIZE_EN.
//
// state  | meaning
// LOAD   | accepting pixel beats into buf at idx
// DRAIN  | frame overran NPIX; discard beats until last
// SETTLE | core out of reset, waiting SETTLE_CYCLES
// RESULT | result held on m_res_* until accepted
module mnist_frame_loader
  import mnist_pkg::*;
#(
  parameter int NPIX_P        = mnist_pkg::NPIX,
  parameter int SETTLE_CYCLES = 900,
  parameter int IDX_W         = 10,
  parameter int CNT_W         = 12
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             s_pix_data,
  input  logic                   s_pix_valid,
  output logic                   s_pix_ready,
  input  logic                   s_pix_last,
  output logic [NPIX_P*32-1:0]   pixel_out,
  output logic                   nn_rstn,
  input  logic [3:0]             pred_in,
  output logic [7:0]             m_res_data,
  output logic                   m_res_valid,
  input  logic                   m_res_ready,
  output logic                   busy
);

  localparam logic [1:0] S_LOAD   = 2'(ST_LOAD);
  localparam logic [1:0] S_DRAIN  = 2'(ST_DRAIN);
  localparam logic [1:0] S_SETTLE = 2'(ST_SETTLE);
  localparam logic [1:0] S_RESULT = 2'(ST_RESULT);

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   err_q, err_d;
  logic [7:0]             res_q, res_d;
  logic                   nn_rstn_q, nn_rstn_d;
  logic                   wr_en;
  logic                   timer_start;
  logic                   timer_done;
  logic [NPIX_P-1:0][31:0] buf_q;
  q16_t                   wr_word;

  assign wr_word = pix_to_q16(s_pix_data);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_d       = err_q;
    res_d       = res_q;
    nn_rstn_d   = nn_rstn_q;
    wr_en       = 1'b0;
    timer_start = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (s_pix_valid) begin
          wr_en = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NPIX_P - 1)) begin
            if (s_pix_last) begin
              state_d     = S_SETTLE;
              nn_rstn_d   = 1'b1;
              timer_start = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (s_pix_last) begin
            // Short frame: report error without running the core.
            err_d   = 1'b1;
            res_d   = 8'h80;
            state_d = S_RESULT;
          end
        end
      end
      S_DRAIN: begin
        if (s_pix_valid && s_pix_last) begin
          state_d     = S_SETTLE;
          nn_rstn_d   = 1'b1;
          timer_start = 1'b1;
        end
      end
      S_SETTLE: begin
        if (timer_done) begin
          res_d     = {err_q, 3'b000, pred_in};
          nn_rstn_d = 1'b0;
          state_d   = S_RESULT;
        end
      end
      default: begin
        if (m_res_ready) begin
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_LOAD;
      idx_q     <= '0;
      err_q     <= 1'b0;
      res_q     <= '0;
      nn_rstn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      res_q     <= res_d;
      nn_rstn_q <= nn_rstn_d;
    end
  end

  for (genvar i = 0; i < NPIX_P; i++) begin : g_buf
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                              buf_q[i] <= '0;
      else if (wr_en && idx_q == IDX_W'(i))   buf_q[i] <= wr_word;
    end
  end

  mnist_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_settle_timer (
    .clk    (clk),
    .rstn   (rstn),
    .start_i(timer_start),
    .done_o (timer_done)
  );

  assign pixel_out   = buf_q;
  assign s_pix_ready = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign m_res_valid = (state_q == S_RESULT);
  assign m_res_data  = res_q;
  assign nn_rstn     = nn_rstn_q;
  assign busy        = !((state_q == S_LOAD) && (idx_q == '0));

endmodule

// File: tb/tb_mnist_frame_loader.sv
// Self-checking bench for mnist_frame_loader against a frame-level reference model.
module tb_mnist_frame_loader;

  localparam int NPIX   = 784;
  localparam int SETTLE = 900;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [7:0]           s_pix_data = '0;
  logic                 s_pix_valid = 1'b0;
  logic                 s_pix_ready;
  logic                 s_pix_last = 1'b0;
  logic [NPIX*32-1:0]   pixel_out;
  logic                 nn_rstn;
  logic [3:0]           pred_in = '0;
  logic [7:0]           m_res_data;
  logic                 m_res_valid;
  logic                 m_res_ready = 1'b0;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_buf [NPIX];

  always #5 clk = ~clk;

  mnist_frame_loader dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_pix_data (s_pix_data),
    .s_pix_valid(s_pix_valid),
    .s_pix_ready(s_pix_ready),
    .s_pix_last (s_pix_last),
    .pixel_out  (pixel_out),
    .nn_rstn    (nn_rstn),
    .pred_in    (pred_in),
    .m_res_data (m_res_data),
    .m_res_valid(m_res_valid),
    .m_res_ready(m_res_ready),
    .busy       (busy)
  );

  function automatic logic [31:0] conv(input int p);
`ifdef MNIST_LOADER_NORMALIZE_EN
    return 32'(p * 257);
`else
    return 32'(p * 256);
`endif
  endfunction

  function automatic logic [31:0] word(input int i);
    return pixel_out[i*32 +: 32];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_buf(input string tag);
    int nbad = 0;
    for (int i = 0; i < NPIX; i++)
      if (word(i) !== model_buf[i]) nbad++;
    check(tag, 32'(nbad), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    int nz = 0;
    for (int i = 0; i < NPIX; i++)
      if (word(i) !== 32'd0) nz++;
    check({tag, "_ready"}, 32'(s_pix_ready), 32'd1);
    check({tag, "_valid"}, 32'(m_res_valid), 32'd0);
    check({tag, "_data"},  32'(m_res_data),  32'd0);
    check({tag, "_nnrstn"}, 32'(nn_rstn),    32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_pixzero"}, 32'(nz),        32'd0);
  endtask

  // Drives one frame of nbeats, then follows it through settle and the result handshake.
  task automatic run_frame(input string tag, input int nbeats, input bit rnd_data,
                           input bit gaps, input int bp, input logic [3:0] pred);
    int last = nbeats - 1;
    int rdy_bad = 0;
    int k = 0;
    int nn_drop = 0;
    int bp_bad = 0;
    int d;
    logic [7:0] exp_res;
    pred_in = pred;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          s_pix_valid = 1'b0;
          s_pix_last  = 1'b0;
          @(negedge clk);
        end
      end
      d = rnd_data ? int'($urandom_range(0, 255)) : (b % 256);
      s_pix_data  = 8'(d);
      s_pix_valid = 1'b1;
      s_pix_last  = (b == last);
      if (s_pix_ready !== 1'b1) rdy_bad++;
      if (b < NPIX) model_buf[b] = conv(d);
      @(negedge clk);
      if (b == 0) check({tag, "_busy_after_first"}, 32'(busy), 32'd1);
      if (b == 5) check({tag, "_pix5_next_cycle"}, word(5), model_buf[5]);
    end
    s_pix_valid = 1'b0;
    s_pix_last  = 1'b0;
    check({tag, "_ready_during_frame"}, 32'(rdy_bad), 32'd0);
    check({tag, "_ready_after_last"}, 32'(s_pix_ready), 32'd0);

    if (last < NPIX - 1)       exp_res = 8'h80;
    else if (last == NPIX - 1) exp_res = {4'h0, pred};
    else                       exp_res = {4'h8, pred};

    if (last < NPIX - 1) begin
      check({tag, "_short_valid"}, 32'(m_res_valid), 32'd1);
      check({tag, "_short_nnrstn"}, 32'(nn_rstn), 32'd0);
    end else begin
      check({tag, "_nnrstn_rise"}, 32'(nn_rstn), 32'd1);
      while (m_res_valid !== 1'b1 && k < 3 * SETTLE) begin
        @(negedge clk);
        k++;
        if (m_res_valid !== 1'b1 && nn_rstn !== 1'b1) nn_drop++;
      end
      check({tag, "_settle_len"}, 32'(k), 32'(SETTLE));
      check({tag, "_nnrstn_held"}, 32'(nn_drop), 32'd0);
      check({tag, "_nnrstn_fall"}, 32'(nn_rstn), 32'd0);
    end
    check({tag, "_res_data"}, 32'(m_res_data), 32'(exp_res));
    check_buf({tag, "_buf_mismatches"});

    m_res_ready = 1'b0;
    repeat (bp) begin
      @(negedge clk);
      if (m_res_valid !== 1'b1 || m_res_data !== exp_res || s_pix_ready !== 1'b0) bp_bad++;
    end
    if (bp > 0) check({tag, "_backpressure_stable"}, 32'(bp_bad), 32'd0);
    m_res_ready = 1'b1;
    @(negedge clk);
    m_res_ready = 1'b0;
    check({tag, "_valid_after_hs"}, 32'(m_res_valid), 32'd0);
    check({tag, "_ready_after_hs"}, 32'(s_pix_ready), 32'd1);
    check({tag, "_busy_after_hs"},  32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) model_buf[i] = 32'd0;

    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Nominal frame, pattern i%256, pred forced to 7
    run_frame("nominal", NPIX, 1'b0, 1'b0, 0, 4'd7);
    check("nominal_pix5", word(5), conv(5));
`ifdef MNIST_LOADER_NORMALIZE_EN
    check("pix255_const", word(255), 32'h0000FFFF);
`else
    check("pix255_const", word(255), 32'h0000FF00);
`endif

    // Short frame with random data and gaps
    run_frame("short", 100, 1'b1, 1'b1, 0, 4'($urandom_range(0, 9)));

    // Next frame restarts at index 0
    run_frame("after_short", NPIX, 1'b1, 1'b1, 0, 4'($urandom_range(0, 9)));

    // Long frame plus result backpressure
    run_frame("long", NPIX + 6, 1'b1, 1'b0, 50, 4'($urandom_range(0, 9)));

    // Reset mid-frame at beat 400
    for (int b = 0; b < 400; b++) begin
      s_pix_data  = 8'($urandom_range(1, 255));
      s_pix_valid = 1'b1;
      s_pix_last  = 1'b0;
      @(negedge clk);
    end
    s_pix_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    for (int i = 0; i < NPIX; i++) model_buf[i] = 32'd0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_frame("post_reset", NPIX, 1'b1, 1'b1, 3, 4'($urandom_range(0, 9)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
